// File: rtl/register_pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : register_pipeline_pkg                                  |
// | Description : Shared definitions for elastic valid/ready blocks:     |
// |               occupancy-counter width helper and the handshake-pair  |
// |               record used when bundling a channel into one signal.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package register_pipeline_pkg;

   // Default payload width of the bundled handshake record.
   localparam int unsigned HS_DATA_W = 32;

   // Width of a counter able to hold every value from 0 to depth inclusive.
   function automatic int unsigned COUNT_W(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // One valid/ready channel with its payload, for sibling elastic blocks
   // that pass a whole channel through a single port or array element.
   typedef struct packed {
      logic                 valid;
      logic                 ready;
      logic [HS_DATA_W-1:0] data;
   } hs_pair_t;

endpackage : register_pipeline_pkg
`default_nettype wire

// File: rtl/register_pipeline_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : register_pipeline_stage                                |
// | Description : One elastic stage: a valid bit plus a data word. Loads |
// |               from upstream when enabled; flush drops the valid bit  |
// |               while the data word keeps its last value.              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module register_pipeline_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             flush_i,
   input  logic             up_valid_i,
   input  logic [WIDTH-1:0] up_data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q;
   logic             valid_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Next state: flush wins over load; data only moves with a valid word so
   // bubbles never overwrite the last real payload.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = up_valid_i;
         if (up_valid_i) begin
            data_d = up_data_i;
         end
      end
   end

   // Stage registers, cleared asynchronously so no partial state survives reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule : register_pipeline_stage
`default_nettype wire

// File: rtl/register_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : register_pipeline                                      |
// | Description : Chain of DEPTH elastic register stages with a          |
// |               valid/ready handshake, synchronous flush and a         |
// |               registered occupancy count. Full throughput; stalls    |
// |               hold data without loss and bubbles collapse.           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module register_pipeline
   import register_pipeline_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = COUNT_W(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_o,
   output logic [CNT_W-1:0] count_o
);

   logic [DEPTH-1:0] w_valid;
   logic [DEPTH-1:0] w_ready;
   logic [WIDTH-1:0] w_data [DEPTH];

   logic             w_in_xfer;
   logic             w_out_xfer;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Ready chain: a stage can load when it is empty or its successor is
   // taking its word this cycle. The last stage looks at the consumer, so
   // out_ready_i reaches in_ready_o through DEPTH gates.
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_ready
         if (i == DEPTH - 1) begin : g_last
            assign w_ready[i] = !w_valid[i] || out_ready_i;
         end else begin : g_mid
            assign w_ready[i] = !w_valid[i] || w_ready[i+1];
         end
      end
   endgenerate

   // Stage chain: stage 0 takes the producer's word, every other stage takes
   // its predecessor's.
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
         logic             w_up_valid;
         logic [WIDTH-1:0] w_up_data;

         if (i == 0) begin : g_first
            assign w_up_valid = in_valid_i;
            assign w_up_data  = in_i;
         end else begin : g_rest
            assign w_up_valid = w_valid[i-1];
            assign w_up_data  = w_data[i-1];
         end

         register_pipeline_stage #(
            .WIDTH (WIDTH)
         ) u_stage (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .load_i     (w_ready[i]),
            .flush_i    (clear_i),
            .up_valid_i (w_up_valid),
            .up_data_i  (w_up_data),
            .valid_o    (w_valid[i]),
            .data_o     (w_data[i])
         );
      end
   endgenerate

   assign in_ready_o  = w_ready[0];
   assign out_valid_o = w_valid[DEPTH-1];
   assign out_o       = w_data[DEPTH-1];

   assign w_in_xfer   = in_valid_i && w_ready[0];
   assign w_out_xfer  = w_valid[DEPTH-1] && out_ready_i;

   // Occupancy tracks transfers rather than recounting valid bits, so the
   // count is a plain register with an incrementer; flush zeroes it along
   // with the valid bits.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (w_in_xfer && !w_out_xfer) begin
         count_d = count_q + CNT_W'(1);
      end else if (!w_in_xfer && w_out_xfer) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Occupancy register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule : register_pipeline
`default_nettype wire
